seq_pattern_gen: RTL and testbench

Serial bit-pattern transmitter that drives the single-bit `start` input of the lab Mealy sequence detectors. It serializes a loaded PAT_W-bit pattern MSB-first, one bit per clock, for a programmable number of copies. Copies can be sent back-to-back, which exercises overlapping detection, or separated by idle gap cycles. It sits between the testbench/top-level control and the detector under test, and gives the detector a cycle-accurate, repeatable stimulus stream.

---
 rtl/seq_pattern_gen.sv | 153 +++++++++++++++
 tb/tb_seq_pattern_gen.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen
// Serial bit-pattern transmitter that feeds the single-bit `start` input of the
// lab Mealy sequence detectors. A PAT_W-bit pattern is sent MSB-first, one bit
// per clock, for repeat+1 copies. Copies are either back-to-back (GAP=0) or
// separated by GAP idle cycles.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-high
//   load        capture pattern_in/repeat_in (only honoured in IDLE)
//   pattern_in  pattern to send, bit PAT_W-1 goes out first
//   repeat_in   extra copies; copies sent = repeat_in+1
//   start       begin a transmission (only honoured in IDLE)
//   abort       synchronous cancel of SEND/GAP, no done pulse
//   serial_out  transmitted bit
//   bit_valid   serial_out carries a pattern bit this cycle
//   busy        transmission in progress (SEND or GAP)
//   done        one-cycle pulse the cycle after the final bit
//   state_dbg   current FSM state encoding, for checkers
//
// Handshake: bit_valid qualifies serial_out on every cycle it is high; there
// is no backpressure, so the consumer must take each valid bit as it appears.
// All outputs are registered from the next-state decode, so they reflect the
// state the FSM is in during that cycle and never depend combinationally on
// the inputs.
module seq_pattern_gen #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 4,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [PAT_W-1:0] pattern_in,
  input  logic [CNT_W-1:0] repeat_in,
  input  logic             start,
  input  logic             abort,
  output logic             serial_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_dbg
);

  localparam int IDX_W = $clog2(PAT_W);
  // GAP=0 still needs a legal (unused) counter width.
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(PAT_W - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [PAT_W-1:0] pat_q, pat_n;
  logic [CNT_W-1:0] rep_q, rep_n;
  logic [IDX_W-1:0] idx_q, idx_n;
  logic [CNT_W-1:0] copy_q, copy_n;
  logic [GAP_W-1:0] gap_q, gap_n;
  logic             serial_n, valid_n, busy_n, done_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      pat_q      <= '0;
      rep_q      <= '0;
      idx_q      <= '0;
      copy_q     <= '0;
      gap_q      <= '0;
      serial_out <= 1'b0;
      bit_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      pat_q      <= pat_n;
      rep_q      <= rep_n;
      idx_q      <= idx_n;
      copy_q     <= copy_n;
      gap_q      <= gap_n;
      serial_out <= serial_n;
      bit_valid  <= valid_n;
      busy       <= busy_n;
      done       <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    pat_n   = pat_q;
    rep_n   = rep_q;
    idx_n   = idx_q;
    copy_n  = copy_q;
    gap_n   = gap_q;

    case (state)
      S_IDLE: begin
        // A simultaneous load lands first so the start below uses it.
        if (load) begin
          pat_n = pattern_in;
          rep_n = repeat_in;
        end
        if (start) begin
          state_n = S_SEND;
          idx_n   = IDX_MAX;
          copy_n  = rep_n;
        end
      end
      S_SEND: begin
        if (abort) begin
          state_n = S_IDLE;
        end else if (idx_q != '0) begin
          idx_n = idx_q - IDX_W'(1);
        end else if (copy_q != '0) begin
          copy_n  = copy_q - CNT_W'(1);
          idx_n   = IDX_MAX;
          gap_n   = GAP_LAST;
          state_n = (GAP > 0) ? S_GAP : S_SEND;
        end else begin
          state_n = S_DONE;
        end
      end
      S_GAP: begin
        if (abort) begin
          state_n = S_IDLE;
        end else if (gap_q == '0) begin
          state_n = S_SEND;
        end else begin
          gap_n = gap_q - GAP_W'(1);
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    // Output decode from the state being entered, registered above.
    serial_n = (state_n == S_SEND) && pat_n[idx_n];
    valid_n  = (state_n == S_SEND);
    busy_n   = (state_n == S_SEND) || (state_n == S_GAP);
    done_n   = (state_n == S_DONE);
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Bench for seq_pattern_gen: two instances (GAP=0 and GAP=2) with separate
// stimulus. Expected output vectors {serial_out, bit_valid, busy, done} are
// pushed per cycle when stimulus is driven; a negedge monitor pops and compares
// one vector per cycle, expecting all-zero outputs whenever the queue is empty.
module tb_seq_pattern_gen;

  localparam int PAT_W = 4;
  localparam int CNT_W = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  logic             load[2];
  logic             start[2];
  logic             abort[2];
  logic [PAT_W-1:0] pattern_in[2];
  logic [CNT_W-1:0] repeat_in[2];
  logic             serial_out[2];
  logic             bit_valid[2];
  logic             busy[2];
  logic             done[2];
  logic [1:0]       state_dbg[2];

  logic [3:0] exp_q0[$];
  logic [3:0] exp_q1[$];
  logic [3:0] mon_exp;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  typedef struct {
    logic [PAT_W-1:0] pat;
    logic [CNT_W-1:0] rep;
  } run_t;

  run_t runs[5];

  always #5 clk = ~clk;

  seq_pattern_gen #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP(0)) dut0 (
    .clk(clk), .reset(reset), .load(load[0]), .pattern_in(pattern_in[0]),
    .repeat_in(repeat_in[0]), .start(start[0]), .abort(abort[0]),
    .serial_out(serial_out[0]), .bit_valid(bit_valid[0]), .busy(busy[0]),
    .done(done[0]), .state_dbg(state_dbg[0])
  );

  seq_pattern_gen #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP(2)) dut1 (
    .clk(clk), .reset(reset), .load(load[1]), .pattern_in(pattern_in[1]),
    .repeat_in(repeat_in[1]), .start(start[1]), .abort(abort[1]),
    .serial_out(serial_out[1]), .bit_valid(bit_valid[1]), .busy(busy[1]),
    .done(done[1]), .state_dbg(state_dbg[1])
  );

  function automatic logic [3:0] obs(input int d);
    return {serial_out[d], bit_valid[d], busy[d], done[d]};
  endfunction

  task automatic check(input string name, input int d, input logic [3:0] act,
                       input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d actual=%b expected=%b (serial,valid,busy,done) t=%0t",
               name, d, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        mon_exp = 4'b0000;
        if (d == 0 && exp_q0.size() > 0) mon_exp = exp_q0.pop_front();
        else if (d == 1 && exp_q1.size() > 0) mon_exp = exp_q1.pop_front();
        check("stream", d, obs(d), mon_exp);
      end
    end
  end

  task automatic push(input int d, input logic [3:0] v);
    if (d == 0) exp_q0.push_back(v);
    else        exp_q1.push_back(v);
  endtask

  // Expected trace of a run whose start is driven in the current cycle:
  // idle now, then copies (with gap cycles between them), then done.
  task automatic push_run(input int d, input logic [PAT_W-1:0] pat, input int rep);
    int gap;
    gap = (d == 0) ? 0 : 2;
    push(d, 4'b0000);
    for (int c = 0; c <= rep; c++) begin
      if (c > 0) for (int g = 0; g < gap; g++) push(d, 4'b0010);
      for (int b = PAT_W - 1; b >= 0; b--) push(d, {pat[b], 1'b1, 1'b1, 1'b0});
    end
    push(d, 4'b0001);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input logic ld, input logic [PAT_W-1:0] pat,
                       input logic [CNT_W-1:0] rep, input logic st, input logic ab);
    load[d]       = ld;
    pattern_in[d] = pat;
    repeat_in[d]  = rep;
    start[d]      = st;
    abort[d]      = ab;
  endtask

  task automatic idle(input int d);
    drive(d, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400; i++) begin
      if (exp_q0.size() == 0 && exp_q1.size() == 0) return;
      tick();
    end
    checks++;
    failures++;
    $display("FAIL drain_timeout q0=%0d q1=%0d required=0 t=%0t",
             exp_q0.size(), exp_q1.size(), $time);
  endtask

  initial begin
    runs[0] = '{pat: 4'b1011, rep: 4'd0};
    runs[1] = '{pat: 4'b1101, rep: 4'd2};
    runs[2] = '{pat: 4'b1001, rep: 4'd1};
    runs[3] = '{pat: 4'b1111, rep: 4'd15};
    runs[4] = '{pat: 4'b0110, rep: 4'd3};

    idle(0);
    idle(1);
    #1 reset = 1'b1;
    tick();
    tick();
    for (int d = 0; d < 2; d++) begin
      check("reset_out", d, obs(d), 4'b0000);
      check("reset_state", d, {2'b00, state_dbg[d]}, 4'b0000);
    end
    reset  = 1'b0;
    mon_en = 1'b1;
    tick();
    tick();

    // Table runs on both instances, load and start in the same cycle.
    for (int i = 0; i < 5; i++) begin
      for (int d = 0; d < 2; d++) begin
        drive(d, 1'b1, runs[i].pat, runs[i].rep, 1'b1, 1'b0);
        push_run(d, runs[i].pat, int'(runs[i].rep));
      end
      tick();
      idle(0);
      idle(1);
      wait_drain();
    end

    // Ignore rules: load/start during SEND change nothing; pattern retained.
    drive(0, 1'b1, 4'b1011, 4'd0, 1'b1, 1'b0);
    push_run(0, 4'b1011, 0);
    tick();
    idle(0);
    tick();
    drive(0, 1'b1, 4'b0110, 4'd3, 1'b1, 1'b0);
    tick();
    idle(0);
    wait_drain();
    tick();
    tick();
    drive(0, 1'b0, 4'b0110, 4'd3, 1'b1, 1'b0);
    push_run(0, 4'b1011, 0);
    tick();
    idle(0);
    wait_drain();

    // Abort on the 3rd bit of copy 1 of 3; then replay retained settings.
    drive(0, 1'b1, 4'b1011, 4'd2, 1'b1, 1'b0);
    push(0, 4'b0000);
    push(0, 4'b1110);
    push(0, 4'b0110);
    push(0, 4'b1110);
    tick();
    idle(0);
    tick();
    tick();
    drive(0, 1'b0, '0, '0, 1'b0, 1'b1);
    tick();
    idle(0);
    tick();
    tick();
    tick();
    drive(0, 1'b0, '0, '0, 1'b1, 1'b0);
    push_run(0, 4'b1011, 2);
    tick();
    idle(0);
    wait_drain();

    // Abort during a GAP cycle.
    drive(1, 1'b1, 4'b1001, 4'd1, 1'b1, 1'b0);
    push(1, 4'b0000);
    push(1, 4'b1110);
    push(1, 4'b0110);
    push(1, 4'b0110);
    push(1, 4'b1110);
    push(1, 4'b0010);
    for (int c = 0; c < 5; c++) begin
      tick();
      idle(1);
    end
    drive(1, 1'b0, '0, '0, 1'b0, 1'b1);
    tick();
    idle(1);
    tick();
    tick();
    wait_drain();

    // Start held high: each restart comes two cycles after done.
    drive(0, 1'b1, 4'b1101, 4'd1, 1'b1, 1'b0);
    push_run(0, 4'b1101, 1);
    tick();
    drive(0, 1'b0, '0, '0, 1'b1, 1'b0);
    for (int r = 0; r < 2; r++) begin
      wait_drain();
      push_run(0, 4'b1101, 1);
      tick();
    end
    wait_drain();
    idle(0);
    tick();
    tick();

    // Asynchronous reset while dut1 sits in its first GAP cycle.
    for (int d = 0; d < 2; d++) begin
      drive(d, 1'b1, 4'b1001, 4'd1, 1'b1, 1'b0);
      push_run(d, 4'b1001, 1);
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      idle(0);
      idle(1);
    end
    @(negedge clk);
    #2;
    mon_en = 1'b0;
    reset  = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) check("reset_async", d, obs(d), 4'b0000);
    exp_q0.delete();
    exp_q1.delete();
    tick();
    reset  = 1'b0;
    mon_en = 1'b1;
    tick();
    // Pattern register was cleared: PAT_W zeros with bit_valid, then done.
    for (int d = 0; d < 2; d++) begin
      drive(d, 1'b0, '0, '0, 1'b1, 1'b0);
      push_run(d, 4'b0000, 0);
    end
    tick();
    idle(0);
    idle(1);
    wait_drain();
    tick();
    tick();

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
